// File: rtl/fft_peak_picker.sv
// fft_peak_picker: Avalon-ST sink for the FFT source port. It checks frame
// framing, estimates each bin's magnitude as max(|re|,|im|) + min(|re|,|im|)/2
// and reports the strongest bin in [MIN_BIN, MAX_BIN] once per clean frame.
module fft_peak_picker #(
  parameter int DATA_W  = 32,
  parameter int N_LOG2  = 13,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 4095
) (
  input  logic              CLOCK_50,
  input  logic              AUD_ADCLRCK,
  input  logic              enable,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              src_sop,
  input  logic              src_eop,
  input  logic [1:0]        src_error,
  input  logic [DATA_W-1:0] src_real,
  input  logic [DATA_W-1:0] src_imag,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [DATA_W:0]   peak_mag,
  output logic              peak_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [N_LOG2-1:0] LAST_IDX = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] ZERO_IDX = {N_LOG2{1'b0}};
  localparam logic [N_LOG2-1:0] ONE_IDX  = {{(N_LOG2-1){1'b0}}, 1'b1};
  localparam logic [N_LOG2-1:0] MIN_IDX  = N_LOG2'(MIN_BIN);
  localparam logic [N_LOG2-1:0] MAX_IDX  = N_LOG2'(MAX_BIN);
  localparam logic [DATA_W-2:0] ABS_MAX  = {(DATA_W-1){1'b1}};
  localparam logic [DATA_W:0]   MAG_ZERO = {(DATA_W+1){1'b0}};

  // Absolute value of a two's complement sample; the most negative code has
  // no positive twin, so it saturates to the largest positive value.
  function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] neg;
    neg = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    if (!v[DATA_W-1]) begin
      sat_abs = v[DATA_W-2:0];
    end else if (v[DATA_W-2:0] == {(DATA_W-1){1'b0}}) begin
      sat_abs = ABS_MAX;
    end else begin
      sat_abs = neg[DATA_W-2:0];
    end
  endfunction

  logic [1:0]        state_r, state_s;
  logic [N_LOG2-1:0] bin_cnt_r, bin_cnt_s;
  logic              err_r, err_s;
  logic [1:0]        drain_cnt_r, drain_cnt_s;
  logic              src_ready_r, accept_s, bad_s;
  logic              frame_err_s, peak_load_s, push_s, push_sop_s;
  logic [N_LOG2-1:0] push_idx_s;
  logic              frame_err_r, peak_valid_r, busy_r;
  logic [N_LOG2-1:0] peak_bin_r;
  logic [DATA_W:0]   peak_mag_r;

  // Pipeline: each entry carries a sop tag so that a restart only clears the
  // running best when its own bin 0 reaches the compare stage.
  logic              s1_v_r, s1_sop_r, s2_v_r, s2_sop_r;
  logic [N_LOG2-1:0] s1_idx_r, s2_idx_r;
  logic [DATA_W-2:0] s1_a_r, s1_b_r, max_s, min_s;
  logic [DATA_W:0]   mag_s, s2_mag_r;
  logic [DATA_W:0]   best_mag_r, best_mag_s, base_mag_s;
  logic [N_LOG2-1:0] best_bin_r, best_bin_s, base_bin_s;
  logic              in_range_s;

  assign accept_s = src_valid & src_ready_r;
  assign bad_s    = (src_error != 2'b00);

  // Framing FSM next-state logic over accepted beats only.
  always_comb begin
    state_s     = state_r;
    bin_cnt_s   = bin_cnt_r;
    err_s       = err_r;
    drain_cnt_s = drain_cnt_r;
    frame_err_s = 1'b0;
    peak_load_s = 1'b0;
    push_s      = 1'b0;
    push_sop_s  = 1'b0;
    push_idx_s  = bin_cnt_r;
    case (state_r)
      ST_HUNT: begin
        if (accept_s && src_sop) begin
          state_s    = ST_FRAME;
          bin_cnt_s  = ONE_IDX;
          err_s      = bad_s;
          push_s     = 1'b1;
          push_sop_s = 1'b1;
          push_idx_s = ZERO_IDX;
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_FRAME: begin
        if (accept_s) begin
          push_s = 1'b1;
          if (src_sop) begin
            // Restart wins over a simultaneous eop.
            frame_err_s = 1'b1;
            bin_cnt_s   = ONE_IDX;
            err_s       = bad_s;
            push_sop_s  = 1'b1;
            push_idx_s  = ZERO_IDX;
          end else begin
            bin_cnt_s = bin_cnt_r + ONE_IDX;
            err_s     = err_r | bad_s;
            if (src_eop && (bin_cnt_r == LAST_IDX) && !(err_r | bad_s)) begin
              state_s     = ST_DRAIN;
              drain_cnt_s = 2'd0;
            end else if (src_eop || (bin_cnt_r == LAST_IDX)) begin
              state_s     = ST_HUNT;
              frame_err_s = 1'b1;
            end else begin
              state_s = ST_FRAME;
            end
          end
        end else begin
          state_s = ST_FRAME;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 2'd3) begin
          peak_load_s = 1'b1;
          state_s     = ST_HUNT;
        end else begin
          drain_cnt_s = drain_cnt_r + 2'd1;
        end
      end
      default: begin
        state_s = ST_HUNT;
      end
    endcase
  end

  // Stage 2 magnitude estimate: larger part plus half of the smaller one.
  always_comb begin
    if (s1_a_r >= s1_b_r) begin
      max_s = s1_a_r;
      min_s = s1_b_r;
    end else begin
      max_s = s1_b_r;
      min_s = s1_a_r;
    end
    mag_s = {2'b00, max_s} + {3'b000, min_s[DATA_W-2:1]};
  end

  // Stage 3 peak search: strict compare keeps the lowest bin on ties.
  always_comb begin
    base_mag_s = s2_sop_r ? MAG_ZERO : best_mag_r;
    base_bin_s = s2_sop_r ? MIN_IDX : best_bin_r;
    in_range_s = (s2_idx_r >= MIN_IDX) && (s2_idx_r <= MAX_IDX);
    if (s2_v_r && in_range_s && (s2_mag_r > base_mag_s)) begin
      best_mag_s = s2_mag_r;
      best_bin_s = s2_idx_r;
    end else if (s2_v_r) begin
      best_mag_s = base_mag_s;
      best_bin_s = base_bin_s;
    end else begin
      best_mag_s = best_mag_r;
      best_bin_s = best_bin_r;
    end
  end

  // State, counters, pipeline registers and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge AUD_ADCLRCK) begin
    if (AUD_ADCLRCK) begin
      state_r      <= ST_HUNT;
      bin_cnt_r    <= ZERO_IDX;
      err_r        <= 1'b0;
      drain_cnt_r  <= 2'd0;
      src_ready_r  <= 1'b0;
      s1_v_r       <= 1'b0;
      s1_sop_r     <= 1'b0;
      s1_idx_r     <= ZERO_IDX;
      s1_a_r       <= {(DATA_W-1){1'b0}};
      s1_b_r       <= {(DATA_W-1){1'b0}};
      s2_v_r       <= 1'b0;
      s2_sop_r     <= 1'b0;
      s2_idx_r     <= ZERO_IDX;
      s2_mag_r     <= MAG_ZERO;
      best_mag_r   <= MAG_ZERO;
      best_bin_r   <= MIN_IDX;
      peak_bin_r   <= ZERO_IDX;
      peak_mag_r   <= MAG_ZERO;
      peak_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      bin_cnt_r    <= bin_cnt_s;
      err_r        <= err_s;
      drain_cnt_r  <= drain_cnt_s;
      src_ready_r  <= enable | (state_r == ST_FRAME);
      s1_v_r       <= push_s;
      s1_sop_r     <= push_sop_s;
      s1_idx_r     <= push_idx_s;
      s1_a_r       <= sat_abs(src_real);
      s1_b_r       <= sat_abs(src_imag);
      s2_v_r       <= s1_v_r;
      s2_sop_r     <= s1_sop_r;
      s2_idx_r     <= s1_idx_r;
      s2_mag_r     <= mag_s;
      best_mag_r   <= best_mag_s;
      best_bin_r   <= best_bin_s;
      peak_valid_r <= peak_load_s;
      frame_err_r  <= frame_err_s;
      busy_r       <= (state_s != ST_HUNT) || push_s || s1_v_r;
      if (peak_load_s) begin
        peak_bin_r <= best_bin_r;
        peak_mag_r <= best_mag_r;
      end else begin
        peak_bin_r <= peak_bin_r;
        peak_mag_r <= peak_mag_r;
      end
    end
  end

  assign src_ready  = src_ready_r;
  assign peak_bin   = peak_bin_r;
  assign peak_mag   = peak_mag_r;
  assign peak_valid = peak_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fft_peak_picker.sv
// Testbench for fft_peak_picker: table of planted-bin frames, hand-written
// framing error / restart / enable / reset sequences, and one randomized
// frame checked against a plain-arithmetic reference model.
module tb_fft_peak_picker;

  localparam int N       = 8192;
  localparam int MIN_BIN = 1;
  localparam int MAX_BIN = 4095;
  localparam int NEG_MAX = 32'sh8000_0000;

  logic        CLOCK_50 = 1'b0;
  logic        AUD_ADCLRCK = 1'b1;
  logic        enable = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic        src_sop = 1'b0;
  logic        src_eop = 1'b0;
  logic [1:0]  src_error = 2'b00;
  logic [31:0] src_real = 32'd0;
  logic [31:0] src_imag = 32'd0;
  logic [12:0] peak_bin;
  logic [32:0] peak_mag;
  logic        peak_valid;
  logic        frame_err;
  logic        busy;

  fft_peak_picker dut (
    .CLOCK_50(CLOCK_50), .AUD_ADCLRCK(AUD_ADCLRCK), .enable(enable),
    .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop),
    .src_eop(src_eop), .src_error(src_error), .src_real(src_real),
    .src_imag(src_imag), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_valid(peak_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int     checks = 0;
  int     failures = 0;
  int     ferr_seen = 0;
  int     pv_seen = 0;
  int     re_mem[N];
  int     im_mem[N];
  int     prev_bin = 0;
  longint prev_mag = 0;

  typedef struct {
    string  name;
    int     b0, r0, i0, b1, r1, i1, b2, r2, i2;
    int     exp_bin;
    longint exp_mag;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic longint abs_sat(input int x);
    longint v;
    v = x;
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v;
  endfunction

  // Reference: scan the searched range, strict improvement keeps the lowest bin.
  task automatic ref_peak(output int bin, output longint mag);
    longint a, b, m, best;
    best = 0;
    bin  = MIN_BIN;
    for (int k = MIN_BIN; k <= MAX_BIN; k++) begin
      a = abs_sat(re_mem[k]);
      b = abs_sat(im_mem[k]);
      m = (a > b) ? a + b / 2 : b + a / 2;
      if (m > best) begin
        best = m;
        bin  = k;
      end
    end
    mag = best;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < N; k++) begin
      re_mem[k] = 0;
      im_mem[k] = 0;
    end
  endtask

  task automatic plant(input int b, input int r, input int i);
    if (b >= 0) begin
      re_mem[b] = r;
      im_mem[b] = i;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    ferr_seen += int'(frame_err);
    pv_seen   += int'(peak_valid);
  endtask

  task automatic idle(input int n);
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [1:0] err, input int re, input int im);
    int waited;
    waited    = 0;
    src_valid = 1'b1;
    src_sop   = sop;
    src_eop   = eop;
    src_error = err;
    src_real  = re;
    src_imag  = im;
    while (src_ready !== 1'b1 && waited < 20) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      waited++;
    end
    if (waited >= 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout src_ready=%b expected=1", src_ready);
    end
    tick();
  endtask

  task automatic run_frame(input int nbeats, input int eop_at, input int err_at,
                           input int en_drop_at, input bit gaps);
    ferr_seen = 0;
    pv_seen   = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(7) == 0) idle(1);
      if (i == en_drop_at) enable = 1'b0;
      beat(i == 0, i == eop_at, (i == err_at) ? 2'b01 : 2'b00, re_mem[i], im_mem[i]);
    end
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
    src_error = 2'b00;
  endtask

  task automatic expect_result(input string name, input int exp_bin, input longint exp_mag);
    check({name, "_no_pulse_in_frame"}, 64'(pv_seen), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        check({name, "_pv_early"}, 64'(peak_valid), 64'd0);
        check({name, "_bin_held"}, 64'(peak_bin), 64'(prev_bin));
      end else begin
        check({name, "_pv_at_4"}, 64'(peak_valid), 64'd1);
        check({name, "_ferr_excl"}, 64'(frame_err), 64'd0);
        check({name, "_bin"}, 64'(peak_bin), 64'(exp_bin));
        check({name, "_mag"}, 64'(peak_mag), 64'(exp_mag));
      end
    end
    tick();
    check({name, "_pv_pulse"}, 64'(peak_valid), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
    prev_bin = exp_bin;
    prev_mag = exp_mag;
  endtask

  task automatic expect_discard(input string name);
    check({name, "_ferr_pulse"}, 64'(ferr_seen), 64'd1);
    idle(6);
    check({name, "_no_pv"}, 64'(pv_seen), 64'd0);
    check({name, "_ferr_once"}, 64'(ferr_seen), 64'd1);
    check({name, "_bin_kept"}, 64'(peak_bin), 64'(prev_bin));
    check({name, "_mag_kept"}, 64'(peak_mag), 64'(prev_mag));
  endtask

  initial begin
    int     rbin;
    longint rmag;

    vecs[0] = '{"t1_single", 440, 1000, 0, -1, 0, 0, -1, 0, 0, 440, 64'd1000};
    vecs[1] = '{"t2_tie", 10, -300, 400, 20, 400, -300, -1, 0, 0, 10, 64'd550};
    vecs[2] = '{"t3_range", 0, 1000000, 0, 5000, 1000000, 0, 100, 5, 0, 100, 64'd5};
    vecs[3] = '{"t4_sat", 7, NEG_MAX, NEG_MAX, -1, 0, 0, -1, 0, 0, 7, 64'd3221225470};
    vecs[4] = '{"t5_top", 4095, 7, 0, 4096, 9, 0, -1, 0, 0, 4095, 64'd7};

    // Reset state.
    #1;
    check("rst_peak_bin", 64'(peak_bin), 64'd0);
    check("rst_peak_mag", 64'(peak_mag), 64'd0);
    check("rst_peak_valid", 64'(peak_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(src_ready), 64'd0);
    repeat (3) @(negedge CLOCK_50);
    AUD_ADCLRCK = 1'b0;
    idle(2);

    // Planted-bin frames from the table.
    for (int v = 0; v < 5; v++) begin
      clear_mem();
      plant(vecs[v].b0, vecs[v].r0, vecs[v].i0);
      plant(vecs[v].b1, vecs[v].r1, vecs[v].i1);
      plant(vecs[v].b2, vecs[v].r2, vecs[v].i2);
      run_frame(N, N - 1, -1, -1, 1'b0);
      check({vecs[v].name, "_no_ferr"}, 64'(ferr_seen), 64'd0);
      expect_result(vecs[v].name, vecs[v].exp_bin, vecs[v].exp_mag);
      idle(2);
    end

    // Early eop, poisoned frame, and missing eop are all discarded.
    for (int k = 0; k < N; k++) begin
      re_mem[k] = int'($urandom_range(2000000)) - 1000000;
      im_mem[k] = int'($urandom_range(2000000)) - 1000000;
    end
    run_frame(4001, 4000, -1, -1, 1'b0);
    expect_discard("early_eop");
    run_frame(N, N - 1, 100, -1, 1'b0);
    expect_discard("src_error");
    run_frame(N, -1, -1, -1, 1'b0);
    expect_discard("no_eop");

    // Restart mid-frame: large stale data must not leak into the new frame.
    for (int k = 0; k < N; k++) begin
      re_mem[k] = 32'sh4000_0000;
      im_mem[k] = 32'sh4000_0000;
    end
    run_frame(3000, -1, -1, -1, 1'b0);
    check("restart_part1_no_ferr", 64'(ferr_seen), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    for (int k = 0; k < N; k++) begin
      re_mem[k] = int'($urandom_range(2097152)) - 1048576;
      im_mem[k] = int'($urandom_range(2097152)) - 1048576;
      if ($urandom_range(1999) == 0) re_mem[k] = NEG_MAX;
    end
    ref_peak(rbin, rmag);
    // enable drops mid-frame: the frame must still complete.
    run_frame(N, N - 1, -1, 5000, 1'b1);
    check("restart_ferr", 64'(ferr_seen), 64'd1);
    expect_result("random", rbin, rmag);
    check("enable_low_ready", 64'(src_ready), 64'd0);
    src_valid = 1'b1;
    src_sop   = 1'b1;
    repeat (3) tick();
    check("enable_low_ignored", 64'(busy), 64'd0);
    idle(1);
    enable = 1'b1;

    // Reset in the middle of a frame: silent discard.
    clear_mem();
    plant(50, 123, 0);
    run_frame(1000, -1, -1, -1, 1'b0);
    AUD_ADCLRCK = 1'b1;
    #1;
    check("mid_rst_bin", 64'(peak_bin), 64'd0);
    check("mid_rst_mag", 64'(peak_mag), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(src_ready), 64'd0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    AUD_ADCLRCK = 1'b0;
    ferr_seen = 0;
    pv_seen   = 0;
    idle(6);
    beat(1'b0, 1'b0, 2'b00, 5, 5);
    beat(1'b0, 1'b1, 2'b00, 5, 5);
    idle(6);
    check("mid_rst_no_pulses", 64'(ferr_seen + pv_seen), 64'd0);
    check("mid_rst_hunt", 64'(busy), 64'd0);
    check("mid_rst_bin_after", 64'(peak_bin), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
